ldst_seq: RTL

LDST_SEQ -- requirements
Module: ldst_seq

---
 rtl/mips_pkg.sv | 25 ++
 rtl/ldst_enc.sv | 19 +
 rtl/ldst_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS load/store definitions: opcodes, sequencer modes and the
// ldst_seq state encoding.
package mips_pkg;

   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2B;

   localparam int OPIDX_W = 5;

   typedef enum logic [1:0] {
      MODE_LW   = 2'b00,
      MODE_SW   = 2'b01,
      MODE_LWSW = 2'b10,
      MODE_ILL  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LW_ISSUE = 3'd1,
      ST_SW_ISSUE = 3'd2,
      ST_CHECK    = 3'd3,
      ST_FIN      = 3'd4
   } state_e;

endpackage

// File: rtl/ldst_enc.sv
// I-type MIPS instruction packer: {opcode, rs, rt, imm} -> instruction word.
module ldst_enc
#(
   parameter int DATA_W = 32
)
(
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [15:0]       imm,
   output logic [DATA_W-1:0] word
);

   logic [31:0] raw;

   assign raw  = {opcode, rs, rt, imm};
   assign word = DATA_W'(raw);

endmodule

// File: rtl/ldst_seq.sv
// Load/store instruction sequencer with optional register/memory readback check.
// Define LDST_SEQ_CHECK_EN to build the CHECK phase; otherwise issue goes straight to FIN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for start
// ST_LW_ISSUE | issuing LW ops 0..NUM_OPS-1
// ST_SW_ISSUE | issuing SW ops 0..NUM_OPS-1
// ST_CHECK    | walking check indices, comparing reg vs mem one cycle later
// ST_FIN      | one cycle, done asserted
module ldst_seq
   import mips_pkg::*;
#(
   parameter int NUM_OPS = 5,
   parameter int RIDX_W  = 5,
   parameter int DATA_W  = 32
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [RIDX_W-1:0] chk_reg_idx,
   output logic [RIDX_W-1:0] chk_mem_idx,
   input  logic [DATA_W-1:0] chk_reg_data,
   input  logic [DATA_W-1:0] chk_mem_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_count
);

   localparam logic [OPIDX_W-1:0] LAST  = OPIDX_W'(NUM_OPS - 1);
   localparam logic [OPIDX_W-1:0] NOPS  = OPIDX_W'(NUM_OPS);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic [OPIDX_W-1:0]  op_idx_q, op_idx_d, nxt_idx;
   logic [DATA_W-1:0]   instr_d, enc_word;
   logic                valid_d, busy_d, done_d, err_d;
   logic [7:0]          cnt_d;
   logic                is_sw;
   logic [5:0]          enc_op;
   logic [4:0]          enc_rs, enc_rt;
   logic [15:0]         enc_imm;

   // Encoder looks at the index that will be current after this edge, so the
   // next op is ready on the same edge that accepts the previous one.
   assign nxt_idx = (instr_valid && instr_ready && op_idx_q != LAST) ? op_idx_q + 1'b1 : op_idx_q;
   assign is_sw   = (state_q == ST_SW_ISSUE);
   assign enc_op  = is_sw ? OP_SW : OP_LW;
   assign enc_rs  = is_sw ? 5'(nxt_idx + NOPS) : 5'(nxt_idx);
   assign enc_rt  = is_sw ? 5'(LAST - nxt_idx) : 5'(nxt_idx);
   assign enc_imm = 16'(nxt_idx);

   ldst_enc #(.DATA_W(DATA_W)) u_enc (
      .opcode (enc_op),
      .rs     (enc_rs),
      .rt     (enc_rt),
      .imm    (enc_imm),
      .word   (enc_word)
   );

`ifdef LDST_SEQ_CHECK_EN
   logic [OPIDX_W-1:0] chk_cnt_q, chk_cnt_d;
   logic [RIDX_W-1:0]  reg_idx_q, reg_idx_d, mem_idx_q, mem_idx_d;

   assign chk_reg_idx = reg_idx_q;
   assign chk_mem_idx = mem_idx_q;
`else
   logic unused_chk_data;

   assign chk_reg_idx     = '0;
   assign chk_mem_idx     = '0;
   assign unused_chk_data = ^{chk_reg_data, chk_mem_data};
`endif

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      op_idx_d = op_idx_q;
      instr_d = instr;
      valid_d = instr_valid;
      busy_d  = busy;
      done_d  = 1'b0;
      err_d   = err;
      cnt_d   = err_count;
`ifdef LDST_SEQ_CHECK_EN
      chk_cnt_d = chk_cnt_q;
      reg_idx_d = reg_idx_q;
      mem_idx_d = mem_idx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d   = 1'b1;
               err_d    = 1'b0;
               cnt_d    = 8'd0;
               op_idx_d = '0;
               mode_d   = mode_e'(mode);
               case (mode_e'(mode))
                  MODE_SW:  state_d = ST_SW_ISSUE;
                  MODE_ILL: begin
                     state_d = ST_FIN;
                     err_d   = 1'b1;
                     done_d  = 1'b1;
                  end
                  default:  state_d = ST_LW_ISSUE;
               endcase
            end
         end
         ST_LW_ISSUE, ST_SW_ISSUE: begin
            if (!instr_valid) begin
               valid_d = 1'b1;
               instr_d = enc_word;
            end else if (instr_ready) begin
               if (op_idx_q == LAST) begin
                  valid_d  = 1'b0;
                  op_idx_d = '0;
                  if (state_q == ST_LW_ISSUE && mode_q == MODE_LWSW) begin
                     state_d = ST_SW_ISSUE;
                  end else begin
`ifdef LDST_SEQ_CHECK_EN
                     state_d   = ST_CHECK;
                     chk_cnt_d = '0;
                     mem_idx_d = '0;
                     reg_idx_d = (mode_q == MODE_LW) ? '0 : RIDX_W'(LAST);
`else
                     state_d = ST_FIN;
                     done_d  = 1'b1;
`endif
                  end
               end else begin
                  op_idx_d = nxt_idx;
                  instr_d  = enc_word;
               end
            end
         end
         ST_CHECK: begin
`ifdef LDST_SEQ_CHECK_EN
            // Count 0 only presents the first index; data lags one cycle.
            if (chk_cnt_q != '0 && chk_reg_data != chk_mem_data) begin
               err_d = 1'b1;
               if (err_count != 8'hFF) cnt_d = err_count + 8'd1;
            end
            if (chk_cnt_q == NOPS) begin
               state_d   = ST_FIN;
               done_d    = 1'b1;
               reg_idx_d = '0;
               mem_idx_d = '0;
            end else begin
               chk_cnt_d = chk_cnt_q + 1'b1;
               if (chk_cnt_q != LAST) begin
                  mem_idx_d = RIDX_W'(chk_cnt_q + 1'b1);
                  reg_idx_d = (mode_q == MODE_LW) ? RIDX_W'(chk_cnt_q + 1'b1)
                                                  : RIDX_W'(LAST - chk_cnt_q - 1'b1);
               end
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_LW;
         op_idx_q    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         op_idx_q    <= op_idx_d;
         instr       <= instr_d;
         instr_valid <= valid_d;
         busy        <= busy_d;
         done        <= done_d;
         err         <= err_d;
         err_count   <= cnt_d;
      end
   end

`ifdef LDST_SEQ_CHECK_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chk_cnt_q <= '0;
         reg_idx_q <= '0;
         mem_idx_q <= '0;
      end else begin
         chk_cnt_q <= chk_cnt_d;
         reg_idx_q <= reg_idx_d;
         mem_idx_q <= mem_idx_d;
      end
   end
`endif

endmodule
